// File: rtl/ref_bank_loader_if.sv
// Handshake and bank-write bundle between the reference-data source/consumer and ref_bank_loader.
// The optional wr_word_cnt output (REF_BANK_LOADER_CNT_EN) is a plain port on the loader, not part of this bundle.
interface ref_bank_loader_if #(
  parameter int unsigned NUM_BANK = 4
) ();

  logic                start;
  logic [63:0]         ref_in;
  logic                ref_valid;
  logic                ref_ready;
  logic                seg_release;
  logic [NUM_BANK-1:0] bank_sel;
  logic [6:0]          write_address;
  logic [63:0]         ref_out;
  logic                seg_done;
  logic [1:0]          seg_idx;

  // Source / consumer side
  modport master (
    output start,
    output ref_in,
    output ref_valid,
    output seg_release,
    input  ref_ready,
    input  bank_sel,
    input  write_address,
    input  ref_out,
    input  seg_done,
    input  seg_idx
  );

  // Loader side
  modport slave (
    input  start,
    input  ref_in,
    input  ref_valid,
    input  seg_release,
    output ref_ready,
    output bank_sel,
    output write_address,
    output ref_out,
    output seg_done,
    output seg_idx
  );

endinterface

// File: rtl/ref_bank_loader.sv
// Streams 64-bit reference words into NUM_BANK banks, one segment per bank in turn, with segment credits.
// Optional feature: define REF_BANK_LOADER_CNT_EN to add the saturating wr_word_cnt output.
module ref_bank_loader #(
  parameter int unsigned NUM_BANK  = 4,
  parameter int unsigned SEG_WORDS = 24,
  parameter int unsigned NUM_SEG   = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef REF_BANK_LOADER_CNT_EN
  output logic [15:0] wr_word_cnt,
`endif
  ref_bank_loader_if.slave bif
);

  localparam int unsigned BANK_W = (NUM_BANK  > 1) ? $clog2(NUM_BANK)  : 1;
  localparam int unsigned WORD_W = (SEG_WORDS > 1) ? $clog2(SEG_WORDS) : 1;
  localparam int unsigned SEG_W  = (NUM_SEG   > 1) ? $clog2(NUM_SEG)   : 1;
  localparam int unsigned CRED_W = $clog2(NUM_SEG + 1);
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [CRED_W-1:0]   credits_q, credits_d;

  logic                ready_q;
  logic [NUM_BANK-1:0] sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;
  logic [IDX_W-1:0]    idx_q;

  logic                xfer;
  logic                last_word;
  logic                last_bank;
  logic                seg_end;

  // Control state: FSM plus bank/word/segment/credit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      word_q    <= '0;
      seg_q     <= '0;
      credits_q <= CRED_W'(NUM_SEG);
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      word_q    <= word_d;
      seg_q     <= seg_d;
      credits_q <= credits_d;
    end
  end

  // Next-state and counter advance
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    word_d    = word_q;
    seg_d     = seg_q;
    credits_d = credits_q;

    xfer      = bif.ref_valid & ready_q;
    last_word = (word_q == WORD_W'(SEG_WORDS - 1));
    last_bank = (bank_q == BANK_W'(NUM_BANK - 1));
    seg_end   = xfer & last_word & last_bank;

    // A release in the same cycle as a consume cancels out; releases saturate at NUM_SEG
    if (seg_end && !bif.seg_release) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!seg_end && bif.seg_release && (credits_q != CRED_W'(NUM_SEG))) begin
      credits_d = credits_q + CRED_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bif.start) begin
          state_d   = WRITE;
          bank_d    = '0;
          word_d    = '0;
          seg_d     = '0;
          credits_d = CRED_W'(NUM_SEG);
        end
      end
      WRITE: begin
        if (xfer) begin
          if (last_word) begin
            word_d = '0;
            if (last_bank) begin
              bank_d = '0;
              seg_d  = (seg_q == SEG_W'(NUM_SEG - 1)) ? '0 : seg_q + SEG_W'(1);
              if (credits_d == '0) begin
                state_d = STALL;
              end
            end else begin
              bank_d = bank_q + BANK_W'(1);
            end
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      STALL: begin
        if (credits_q != '0) begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered bank write port; ref_ready mirrors the WRITE state one-for-one
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      sel_q   <= '1;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      ready_q <= (state_d == WRITE);
      done_q  <= seg_end;
      if (xfer) begin
        sel_q  <= ~(NUM_BANK'(1) << bank_q);
        addr_q <= ADDR_W'(seg_q) * ADDR_W'(SEG_WORDS) + ADDR_W'(word_q);
        data_q <= bif.ref_in;
      end else begin
        sel_q  <= '1;
      end
      if (seg_end) begin
        idx_q <= IDX_W'(seg_q);
      end
    end
  end

`ifdef REF_BANK_LOADER_CNT_EN
  logic [15:0] cnt_q;

  // Accepted-word count, sticks at full scale
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign wr_word_cnt = cnt_q;
`endif

  assign bif.ref_ready     = ready_q;
  assign bif.bank_sel      = sel_q;
  assign bif.write_address = addr_q;
  assign bif.ref_out       = data_q;
  assign bif.seg_done      = done_q;
  assign bif.seg_idx       = idx_q;

endmodule
